// File: rtl/testingsb_soc_pkg.sv
// testingsb_soc_pkg
//   Shared definitions for the store-byte MIPS32 integration system:
//   default sizes, MIPS opcode/funct encodings, register indices of the
//   observed temporaries and the ALU operation enumeration.
//   No ports (package).
package testingsb_soc_pkg;

    localparam int ROM_WORDS_DEF = 64;
    localparam int RAM_WORDS_DEF = 64;
    localparam int ERR_W_DEF     = 11;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Observed register indices
    localparam logic [4:0] REG_T0 = 5'd8;
    localparam logic [4:0] REG_T1 = 5'd9;
    localparam logic [4:0] REG_T2 = 5'd10;
    localparam logic [4:0] REG_T3 = 5'd11;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_LUI
    } alu_op_t;

endpackage

// File: rtl/testingsb_soc_if.sv
// testingsb_soc_if
//   Observation bundle of the SoC: temporaries $t0..$t3, data word 0 and
//   the fault status.
//   master : driven by the SoC (all outputs)
//   slave  : observer side (all inputs)
interface testingsb_soc_if #(
    parameter int ERR_W = testingsb_soc_pkg::ERR_W_DEF
);
    logic [31:0]      t_0;
    logic [31:0]      t_1;
    logic [31:0]      t_2;
    logic [31:0]      t_3;
    logic [31:0]      w_0;
    logic             invpc;
    logic             iAddr;
    logic             iOp;
    logic [ERR_W-1:0] error;

    modport master (
        output t_0, t_1, t_2, t_3, w_0, invpc, iAddr, iOp, error
    );

    modport slave (
        input t_0, t_1, t_2, t_3, w_0, invpc, iAddr, iOp, error
    );
endinterface

// File: rtl/testingsb_soc_mips_alu.sv
// mips_alu
//   Combinational 32-bit ALU for the single-cycle core.
//   a, b   : operands (b is register or extended immediate)
//   shamt  : shift amount for sll/srl
//   op     : operation select
//   result : 32-bit wrap-around result
//   zero   : result == 0 (used for beq/bne)
module mips_alu
    import testingsb_soc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_t     op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'h0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = {31'h0, $signed(a) < $signed(b)};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_LUI: result = {b[15:0], 16'h0};
            default: result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/testingsb_soc.sv
// testingsb_soc
//   Single-cycle MIPS32 system running a hard-wired store-byte test program.
//   One instruction retires per rising CLK edge. Holds the register file,
//   big-endian data RAM, program ROM, decode/control and fault capture.
//   CLK   : system clock, rising edge
//   reset : synchronous active-high reset
//   obs   : observation bundle ($t0..$t3, RAM word 0, fault flags, error)
module testingsb_soc
    import testingsb_soc_pkg::*;
#(
    parameter int ROM_WORDS = ROM_WORDS_DEF,
    parameter int RAM_WORDS = RAM_WORDS_DEF,
    parameter int ERR_W     = ERR_W_DEF
) (
    input  logic                   CLK,
    input  logic                   reset,
    testingsb_soc_if.master        obs
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    // Program image; any word outside the listed program reads as nop.
    function automatic logic [31:0] rom_fetch(input logic [29:0] word_idx);
        case (word_idx)
            30'd0:   rom_fetch = 32'h20090000; // addi $t1,$zero,0
            30'd1:   rom_fetch = 32'h00000000; // nop
            30'd2:   rom_fetch = 32'h200800AA; // addi $t0,$zero,0xAA
            30'd3:   rom_fetch = 32'hA1280000; // sb   $t0,0($t1)
            30'd4:   rom_fetch = 32'h200800BB; // addi $t0,$zero,0xBB
            30'd5:   rom_fetch = 32'hA1280001; // sb   $t0,1($t1)
            30'd6:   rom_fetch = 32'h200800CC; // addi $t0,$zero,0xCC
            30'd7:   rom_fetch = 32'hA1280002; // sb   $t0,2($t1)
            30'd8:   rom_fetch = 32'h200800DD; // addi $t0,$zero,0xDD
            30'd9:   rom_fetch = 32'hA1280003; // sb   $t0,3($t1)
            30'd10:  rom_fetch = 32'h1000FFFF; // beq  $zero,$zero,-1
            default: rom_fetch = 32'h00000000;
        endcase
    endfunction

    logic [31:0]      pc;
    logic [31:0]      regs [32];
    logic [31:0]      ram  [RAM_WORDS];
    logic [ERR_W-1:0] err_pc;
    logic             err_seen;

    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, imm_ext;

    // Decode/control outputs
    alu_op_t     alu_op;
    logic        use_imm, imm_zext, reg_write, mem_read, mem_write;
    logic        mem_byte, mem_signed, is_branch, branch_ne, is_jump, op_valid;
    logic [4:0]  dest;

    logic [31:0] alu_b, alu_result;
    logic        alu_zero;

    logic        pc_bad, addr_bad, fault;
    logic [31:0] pc_plus4, branch_target, jump_target, next_pc;

    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_word, load_val, store_word, byte_mask;
    logic [4:0]        lane_shift;
    logic [7:0]        load_byte;
    logic [31:0]       wb_data;

    // An invalid PC fetches a nop so it retires as a plain bubble.
    assign pc_bad = (pc[1:0] != 2'b00) || (pc >= ROM_BYTES);
    assign instr  = pc_bad ? 32'h0 : rom_fetch(pc[31:2]);

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    assign rs_val  = (rs == 5'd0) ? 32'h0 : regs[rs];
    assign rt_val  = (rt == 5'd0) ? 32'h0 : regs[rt];
    assign imm_ext = imm_zext ? {16'h0, imm} : {{16{imm[15]}}, imm};

    // Instruction decode: selects ALU operation, operand source,
    // destination and memory/branch behaviour; flags unsupported encodings.
    always_comb begin
        alu_op     = ALU_ADD;
        use_imm    = 1'b1;
        imm_zext   = 1'b0;
        reg_write  = 1'b0;
        dest       = rt;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_byte   = 1'b0;
        mem_signed = 1'b0;
        is_branch  = 1'b0;
        branch_ne  = 1'b0;
        is_jump    = 1'b0;
        op_valid   = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                use_imm   = 1'b0;
                reg_write = 1'b1;
                dest      = rd;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    default: begin
                        op_valid  = 1'b0;
                        reg_write = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: reg_write = 1'b1;
            OP_SLTI: begin
                alu_op    = ALU_SLT;
                reg_write = 1'b1;
            end
            OP_ANDI: begin
                alu_op    = ALU_AND;
                imm_zext  = 1'b1;
                reg_write = 1'b1;
            end
            OP_ORI: begin
                alu_op    = ALU_OR;
                imm_zext  = 1'b1;
                reg_write = 1'b1;
            end
            OP_XORI: begin
                alu_op    = ALU_XOR;
                imm_zext  = 1'b1;
                reg_write = 1'b1;
            end
            OP_LUI: begin
                alu_op    = ALU_LUI;
                reg_write = 1'b1;
            end
            OP_LW: begin
                mem_read  = 1'b1;
                reg_write = 1'b1;
            end
            OP_LB: begin
                mem_read   = 1'b1;
                mem_byte   = 1'b1;
                mem_signed = 1'b1;
                reg_write  = 1'b1;
            end
            OP_LBU: begin
                mem_read  = 1'b1;
                mem_byte  = 1'b1;
                reg_write = 1'b1;
            end
            OP_SW: mem_write = 1'b1;
            OP_SB: begin
                mem_write = 1'b1;
                mem_byte  = 1'b1;
            end
            OP_BEQ: begin
                alu_op    = ALU_SUB;
                use_imm   = 1'b0;
                is_branch = 1'b1;
            end
            OP_BNE: begin
                alu_op    = ALU_SUB;
                use_imm   = 1'b0;
                is_branch = 1'b1;
                branch_ne = 1'b1;
            end
            OP_J: is_jump = 1'b1;
            default: op_valid = 1'b0;
        endcase
    end

    assign alu_b = use_imm ? imm_ext : rt_val;

    mips_alu u_alu (
        .a      (rs_val),
        .b      (alu_b),
        .shamt  (shamt),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Memory path: the ALU result is the effective address for loads/stores.
    // Lane 0 is the most significant byte (big-endian).
    assign ram_idx    = alu_result[RAM_AW+1:2];
    assign ram_word   = ram[ram_idx];
    assign lane_shift = {2'd3 - alu_result[1:0], 3'b000};
    assign byte_mask  = 32'h000000FF << lane_shift;
    assign load_byte  = 8'(ram_word >> lane_shift);
    assign store_word = mem_byte
                        ? ((ram_word & ~byte_mask) | ({24'h0, rt_val[7:0]} << lane_shift))
                        : rt_val;

    always_comb begin
        load_val = ram_word;
        if (mem_byte) begin
            load_val = mem_signed ? {{24{load_byte[7]}}, load_byte} : {24'h0, load_byte};
        end
    end

    assign addr_bad = (mem_read || mem_write) &&
                      ((alu_result >= RAM_BYTES) || (!mem_byte && alu_result[1:0] != 2'b00));
    assign fault    = pc_bad || !op_valid || addr_bad;
    assign wb_data  = mem_read ? load_val : alu_result;

    // Next-PC selection; a bad PC stalls, other faults just step past.
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (pc_bad) begin
            next_pc = pc;
        end else if (fault) begin
            next_pc = pc_plus4;
        end else if (is_jump) begin
            next_pc = jump_target;
        end else if (is_branch && (alu_zero ^ branch_ne)) begin
            next_pc = branch_target;
        end
    end

    // Architectural state update: retire the current instruction unless
    // reset is asserted, in which case everything clears together.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pc       <= 32'h0;
            err_pc   <= '0;
            err_seen <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
            for (int i = 0; i < RAM_WORDS; i++) begin
                ram[i] <= 32'h0;
            end
        end else begin
            pc <= next_pc;
            if (fault && !err_seen) begin
                err_pc   <= pc[ERR_W-1:0];
                err_seen <= 1'b1;
            end
            if (!fault && reg_write && dest != 5'd0) begin
                regs[dest] <= wb_data;
            end
            if (!fault && mem_write) begin
                ram[ram_idx] <= store_word;
            end
        end
    end

    assign obs.t_0   = regs[REG_T0];
    assign obs.t_1   = regs[REG_T1];
    assign obs.t_2   = regs[REG_T2];
    assign obs.t_3   = regs[REG_T3];
    assign obs.w_0   = ram[0];
    assign obs.invpc = pc_bad;
    assign obs.iAddr = addr_bad;
    assign obs.iOp   = !op_valid;
    assign obs.error = err_pc;

endmodule

// File: tb/tb_testingsb_soc.sv
// tb_testingsb_soc
//   Directed self-checking bench for the store-byte program: reset state,
//   byte-by-byte construction of RAM word 0, self-loop stability and a
//   reset in the middle of the program followed by a full re-run.
module tb_testingsb_soc;

    logic CLK   = 1'b0;
    logic reset = 1'b1;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    testingsb_soc_if obs_if ();

    testingsb_soc dut (
        .CLK   (CLK),
        .reset (reset),
        .obs   (obs_if.master)
    );

    always #5 CLK = ~CLK;

    // Advance n rising edges; returns at a falling edge so outputs are stable.
    task automatic apply_stimulus(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_all_clear(input string tag);
        check_output({tag, " t_0"}, obs_if.t_0, 32'h0);
        check_output({tag, " t_1"}, obs_if.t_1, 32'h0);
        check_output({tag, " t_2"}, obs_if.t_2, 32'h0);
        check_output({tag, " t_3"}, obs_if.t_3, 32'h0);
        check_output({tag, " w_0"}, obs_if.w_0, 32'h0);
        check_output({tag, " flags"}, {29'h0, obs_if.invpc, obs_if.iAddr, obs_if.iOp}, 32'h0);
        check_output({tag, " error"}, {21'h0, obs_if.error}, 32'h0);
    endtask

    // Program sequence from just after reset release through edge 10.
    task automatic check_program(input string tag);
        apply_stimulus(3);
        check_output({tag, " e3 t_0"}, obs_if.t_0, 32'h000000AA);
        check_output({tag, " e3 t_1"}, obs_if.t_1, 32'h00000000);
        check_output({tag, " e3 w_0"}, obs_if.w_0, 32'h00000000);
        apply_stimulus(1);
        check_output({tag, " e4 w_0"}, obs_if.w_0, 32'hAA000000);
        check_output({tag, " e4 t_0"}, obs_if.t_0, 32'h000000AA);
        apply_stimulus(1);
        check_output({tag, " e5 t_0"}, obs_if.t_0, 32'h000000BB);
        check_output({tag, " e5 w_0"}, obs_if.w_0, 32'hAA000000);
        apply_stimulus(1);
        check_output({tag, " e6 w_0"}, obs_if.w_0, 32'hAABB0000);
        apply_stimulus(1);
        check_output({tag, " e7 t_0"}, obs_if.t_0, 32'h000000CC);
        check_output({tag, " e7 w_0"}, obs_if.w_0, 32'hAABB0000);
        apply_stimulus(1);
        check_output({tag, " e8 w_0"}, obs_if.w_0, 32'hAABBCC00);
        apply_stimulus(1);
        check_output({tag, " e9 t_0"}, obs_if.t_0, 32'h000000DD);
        apply_stimulus(1);
        check_output({tag, " e10 w_0"}, obs_if.w_0, 32'hAABBCCDD);
        check_output({tag, " e10 t_0"}, obs_if.t_0, 32'h000000DD);
        check_output({tag, " e10 flags"},
                     {29'h0, obs_if.invpc, obs_if.iAddr, obs_if.iOp}, 32'h0);
    endtask

    initial begin
        $display("[TB] start");

        // Reset held across one rising edge
        reset = 1'b1;
        apply_stimulus(1);
        check_all_clear("reset");

        // Full program run
        reset = 1'b0;
        check_program("run1");

        // Self-loop: state must not drift
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(2);
            check_output("loop w_0", obs_if.w_0, 32'hAABBCCDD);
            check_output("loop t_0", obs_if.t_0, 32'h000000DD);
        end
        check_output("loop t_1", obs_if.t_1, 32'h0);
        check_output("loop t_2", obs_if.t_2, 32'h0);
        check_output("loop t_3", obs_if.t_3, 32'h0);
        check_output("loop flags", {29'h0, obs_if.invpc, obs_if.iAddr, obs_if.iOp}, 32'h0);
        check_output("loop error", {21'h0, obs_if.error}, 32'h0);

        // Restart, then reset after the 6th edge
        reset = 1'b1;
        apply_stimulus(1);
        check_all_clear("reset2");
        reset = 1'b0;
        apply_stimulus(6);
        check_output("mid e6 w_0", obs_if.w_0, 32'hAABB0000);
        check_output("mid e6 t_0", obs_if.t_0, 32'h000000BB);
        reset = 1'b1;
        apply_stimulus(1);
        check_all_clear("midreset");

        // Re-run after mid-program reset reproduces the sequence
        reset = 1'b0;
        check_program("run2");
        apply_stimulus(4);
        check_output("run2 loop w_0", obs_if.w_0, 32'hAABBCCDD);
        check_output("run2 loop error", {21'h0, obs_if.error}, 32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
